// File: rtl/priority_encoder_sync_pkg.sv
// Shared widths and FSM encodings for the debounced priority encoder.
// The rest of the decoder family imports these same definitions.
package priority_encoder_sync_pkg;

    localparam int CODE_W = 3;
    localparam int REQ_W  = 8;
    localparam int CNT_W  = 8;

    typedef enum logic {
        ST_HOLD   = 1'b0,
        ST_SETTLE = 1'b1
    } pe_state_t;

endpackage

// File: rtl/priority_encoder_sync_sync2.sv
// Two-flop synchronizer used to bring switch/button level inputs into clk.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/priority_encoder_sync.sv
// Debounced 8:3 priority encoder: a new {v,y} is committed only after the
// synchronized candidate has held steady for STABLE_CYCLES clocks.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HOLD   | candidate matches committed {v,y}; counter idle at 0
// ST_SETTLE | candidate differs; counting how long the pending value holds
module priority_encoder_sync
    import priority_encoder_sync_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e,
    input  logic [REQ_W-1:0]  d,
    output logic [CODE_W-1:0] y,
    output logic              v,
    output logic              strobe
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [REQ_W:0]      w_sync;
    logic                w_e_s;
    logic [REQ_W-1:0]    w_d_s;
    logic                w_cv;
    logic [CODE_W-1:0]   w_cy;
    logic [CODE_W:0]     w_cand;
    logic [CODE_W:0]     w_cur;
    logic [CODE_W:0]     w_pend;

    pe_state_t           r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_pv;
    logic [CODE_W-1:0]   r_py;
    logic                r_v;
    logic [CODE_W-1:0]   r_y;
    logic                r_strobe;

    function automatic logic [CODE_W-1:0] f_encode(input logic [REQ_W-1:0] req);
        logic [CODE_W-1:0] enc;
        enc = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (req[i]) enc = CODE_W'(i);
        end
        return enc;
    endfunction

    sync2 #(
        .WIDTH(REQ_W + 1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({e, d}),
        .o_q   (w_sync)
    );

    assign w_e_s  = w_sync[REQ_W];
    assign w_d_s  = w_sync[REQ_W-1:0];
    assign w_cv   = w_e_s & (|w_d_s);
    assign w_cy   = w_cv ? f_encode(w_d_s) : '0;
    assign w_cand = {w_cv, w_cy};
    assign w_cur  = {r_v, r_y};
    assign w_pend = {r_pv, r_py};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_HOLD;
            r_cnt    <= '0;
            r_pv     <= 1'b0;
            r_py     <= '0;
            r_v      <= 1'b0;
            r_y      <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ST_HOLD: begin
                    if (w_cand == w_cur) begin
                        r_cnt <= '0;
                    end else begin
                        {r_pv, r_py} <= w_cand;
                        r_cnt        <= CNT_W'(1);
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_cand == w_pend) begin
                        // Terminal compare, so the counter can never pass LAST_CNT
                        if (r_cnt >= LAST_CNT) begin
                            {r_v, r_y} <= w_pend;
                            r_strobe   <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_HOLD;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_cand == w_cur) begin
                        r_cnt   <= '0;
                        r_state <= ST_HOLD;
                    end else begin
                        {r_pv, r_py} <= w_cand;
                        r_cnt        <= CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign y      = r_y;
    assign v      = r_v;
    assign strobe = r_strobe;

endmodule
